// File: rtl/btle_tx_pkg.sv
// rtl/btle_tx_pkg.sv - shared types and constants for the BLE LL transmit framer
package btle_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_AA       = 3'd2,
        ST_PDU      = 3'd3,
        ST_CRC      = 3'd4
    } tx_state_t;

    localparam logic [23:0] CRC24_POLY  = 24'h00065B;
    localparam logic [7:0]  PREAMBLE_AA = 8'hAA;
    localparam logic [7:0]  PREAMBLE_55 = 8'h55;

    localparam int PREAMBLE_BITS = 8;
    localparam int AA_BITS       = 32;
    localparam int CRC_BITS      = 24;

    // Whitening register image {w6..w0}: w0=1, w1..w6 = channel[5..0]
    function automatic logic [6:0] whiten_seed(input logic [5:0] channel);
        return {channel[0], channel[1], channel[2], channel[3], channel[4], channel[5], 1'b1};
    endfunction

endpackage

// File: rtl/btle_tx_bit_framer_if.sv
// rtl/btle_tx_bit_framer_if.sv - control, octet stream and bit stream bundle of the framer
interface btle_tx_bit_framer_if;

    logic        start;
    logic [31:0] access_address;
    logic [23:0] crc_state_init;
    logic [5:0]  channel_number;

    logic [7:0]  pdu_byte;
    logic        pdu_byte_valid;
    logic        pdu_byte_last;
    logic        pdu_byte_ready;

    logic        phy_bit;
    logic        bit_valid;
    logic        bit_valid_last;
    logic        busy;
    logic        underrun;

    modport master (
        output start, access_address, crc_state_init, channel_number,
        output pdu_byte, pdu_byte_valid, pdu_byte_last,
        input  pdu_byte_ready,
        input  phy_bit, bit_valid, bit_valid_last, busy, underrun
    );

    modport slave (
        input  start, access_address, crc_state_init, channel_number,
        input  pdu_byte, pdu_byte_valid, pdu_byte_last,
        output pdu_byte_ready,
        output phy_bit, bit_valid, bit_valid_last, busy, underrun
    );

endinterface

// File: rtl/btle_lfsr_step.sv
// rtl/btle_lfsr_step.sv - single-bit CRC24 and data whitening register updates
module btle_lfsr_step
    import btle_tx_pkg::*;
(
    input  logic [23:0] crc_in,
    input  logic        crc_data,
    output logic [23:0] crc_out,
    input  logic [6:0]  wh_in,
    input  logic        wh_data,
    output logic        wh_bit,
    output logic [6:0]  wh_out
);

    // CRC24 advance by one unwhitened data bit
    always_comb begin
        crc_out = {crc_in[22:0], 1'b0} ^ ((crc_in[23] ^ crc_data) ? CRC24_POLY : 24'h000000);
    end

    // Whitening: output uses w6, then w0<=w6, w4<=w3^w6, others shift up
    always_comb begin
        wh_bit = wh_data ^ wh_in[6];
        wh_out = {wh_in[5], wh_in[4], wh_in[3] ^ wh_in[6], wh_in[2], wh_in[1], wh_in[0], wh_in[6]};
    end

endmodule

// File: rtl/btle_tx_bit_framer.sv
// rtl/btle_tx_bit_framer.sv - BLE LL air packet bit framer; whitening under BTLE_TX_FRAMER_WHITEN_EN
module btle_tx_bit_framer
    import btle_tx_pkg::*;
#(
    parameter int SAMPLE_PER_SYMBOL = 8,
    parameter int MAX_PDU_OCTETS    = 257
) (
    input  logic                 clk,
    input  logic                 rst,
    btle_tx_bit_framer_if.slave  bus
);

    localparam int PW  = (SAMPLE_PER_SYMBOL > 2) ? $clog2(SAMPLE_PER_SYMBOL) : 1;
    localparam int OCW = $clog2(MAX_PDU_OCTETS + 2);
    localparam logic [PW-1:0]  PACE_LAST = PW'(SAMPLE_PER_SYMBOL - 1);
    localparam logic [OCW-1:0] MAX_CNT   = OCW'(MAX_PDU_OCTETS);
    localparam logic [4:0]     PRE_END   = 5'(PREAMBLE_BITS - 1);
    localparam logic [4:0]     AA_END    = 5'(AA_BITS - 1);
    localparam logic [4:0]     CRC_END   = 5'(CRC_BITS - 1);

    tx_state_t        state;
    logic [PW-1:0]    pace;
    logic [4:0]       bit_cnt;
    logic [OCW-1:0]   oct_cnt;
    logic [OCW-1:0]   oct_inc;
    logic [31:0]      aa_reg;
    logic [7:0]       pre_byte;
    logic [23:0]      crc;
    logic [23:0]      crc_next;

    logic [7:0]       buf_data;
    logic             buf_full;
    logic             buf_last;
    logic             last_taken;
    logic             cur_last;
    logic [6:0]       shreg;

    logic             phy_bit_q;
    logic             bit_valid_q;
    logic             bit_last_q;
    logic             busy_q;
    logic             underrun_q;

    logic             ready;
    logic             hs;
    logic             tick;
    logic             octet_start;
    logic             bypass;
    logic [7:0]       oct_data;
    logic             oct_last;
    logic             raw_bit;
    logic             tx_bit;

`ifdef BTLE_TX_FRAMER_WHITEN_EN
    logic [6:0]       wh;
    logic [6:0]       wh_next;
    logic             wh_bit;
`else
    logic [6:0]       wh_unused_next;
    logic             wh_unused_bit;
    logic             ch_unused;
    assign ch_unused = ^bus.channel_number;
`endif

    // Octets are only prefetched once the access address is on the air
    assign ready       = busy_q & ~buf_full & ~last_taken & ((state == ST_AA) | (state == ST_PDU));
    assign hs          = bus.pdu_byte_valid & ready;
    assign tick        = busy_q & (state != ST_IDLE) & (pace == PACE_LAST);
    assign octet_start = tick & (state == ST_PDU) & (bit_cnt == 5'd0);
    // An octet handed over on the very clock it is needed goes straight to the shifter
    assign bypass      = octet_start & ~buf_full & hs;
    assign oct_data    = buf_full ? buf_data : bus.pdu_byte;
    assign oct_last    = buf_full ? buf_last : bus.pdu_byte_last;
    assign oct_inc     = oct_cnt + OCW'(1);

    // Unwhitened bit for the PDU/CRC phases
    always_comb begin
        raw_bit = 1'b0;
        case (state)
            ST_PDU:  raw_bit = (bit_cnt == 5'd0) ? oct_data[0] : shreg[0];
            ST_CRC:  raw_bit = crc[23];
            default: raw_bit = 1'b0;
        endcase
    end

    btle_lfsr_step u_lfsr_step (
        .crc_in   (crc),
        .crc_data (raw_bit),
        .crc_out  (crc_next),
`ifdef BTLE_TX_FRAMER_WHITEN_EN
        .wh_in    (wh),
        .wh_data  (raw_bit),
        .wh_bit   (wh_bit),
        .wh_out   (wh_next)
`else
        .wh_in    (7'd0),
        .wh_data  (1'b0),
        .wh_bit   (wh_unused_bit),
        .wh_out   (wh_unused_next)
`endif
    );

`ifdef BTLE_TX_FRAMER_WHITEN_EN
    assign tx_bit = wh_bit;
`else
    assign tx_bit = raw_bit;
`endif

    // Packet FSM, pacing, octet buffer and registered bit outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pace        <= '0;
            bit_cnt     <= '0;
            oct_cnt     <= '0;
            aa_reg      <= '0;
            pre_byte    <= '0;
            crc         <= '0;
            buf_data    <= '0;
            buf_full    <= 1'b0;
            buf_last    <= 1'b0;
            last_taken  <= 1'b0;
            cur_last    <= 1'b0;
            shreg       <= '0;
            phy_bit_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef BTLE_TX_FRAMER_WHITEN_EN
            wh          <= '0;
`endif
        end else begin
            bit_valid_q <= 1'b0;
            bit_last_q  <= 1'b0;

            if (hs && !bypass) begin
                buf_data <= bus.pdu_byte;
                buf_last <= bus.pdu_byte_last;
                buf_full <= 1'b1;
            end
            if (hs && bus.pdu_byte_last) begin
                last_taken <= 1'b1;
            end
            if (octet_start && buf_full) begin
                buf_full <= 1'b0;
            end
            if (state != ST_IDLE) begin
                pace <= (pace == PACE_LAST) ? '0 : pace + PW'(1);
            end

            case (state)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    if (bus.start && !busy_q) begin
                        aa_reg      <= bus.access_address;
                        pre_byte    <= bus.access_address[0] ? PREAMBLE_55 : PREAMBLE_AA;
                        crc         <= bus.crc_state_init;
`ifdef BTLE_TX_FRAMER_WHITEN_EN
                        wh          <= whiten_seed(bus.channel_number);
`endif
                        underrun_q  <= 1'b0;
                        last_taken  <= 1'b0;
                        buf_full    <= 1'b0;
                        oct_cnt     <= '0;
                        pace        <= '0;
                        busy_q      <= 1'b1;
                        state       <= ST_PREAMBLE;
                        bit_cnt     <= 5'd1;
                        // Preamble LSB equals access_address[0] for both patterns
                        phy_bit_q   <= bus.access_address[0];
                        bit_valid_q <= 1'b1;
                    end
                end

                ST_PREAMBLE: begin
                    if (tick) begin
                        phy_bit_q   <= pre_byte[bit_cnt[2:0]];
                        bit_valid_q <= 1'b1;
                        if (bit_cnt == PRE_END) begin
                            bit_cnt <= '0;
                            state   <= ST_AA;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end

                ST_AA: begin
                    if (tick) begin
                        phy_bit_q   <= aa_reg[bit_cnt];
                        bit_valid_q <= 1'b1;
                        if (bit_cnt == AA_END) begin
                            bit_cnt <= '0;
                            state   <= (MAX_CNT == '0) ? ST_CRC : ST_PDU;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end

                ST_PDU: begin
                    if (tick) begin
                        if (bit_cnt == 5'd0 && !buf_full && !hs) begin
                            underrun_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            phy_bit_q   <= tx_bit;
                            bit_valid_q <= 1'b1;
                            crc         <= crc_next;
`ifdef BTLE_TX_FRAMER_WHITEN_EN
                            wh          <= wh_next;
`endif
                            if (bit_cnt == 5'd0) begin
                                shreg    <= oct_data[7:1];
                                cur_last <= oct_last;
                            end else begin
                                shreg    <= {1'b0, shreg[6:1]};
                            end
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                oct_cnt <= oct_inc;
                                if (cur_last || oct_inc == MAX_CNT) begin
                                    state <= ST_CRC;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                end

                ST_CRC: begin
                    if (tick) begin
                        phy_bit_q   <= tx_bit;
                        bit_valid_q <= 1'b1;
                        crc         <= {crc[22:0], 1'b0};
`ifdef BTLE_TX_FRAMER_WHITEN_EN
                        wh          <= wh_next;
`endif
                        if (bit_cnt == CRC_END) begin
                            bit_last_q <= 1'b1;
                            bit_cnt    <= '0;
                            state      <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pdu_byte_ready = ready;
    assign bus.phy_bit        = phy_bit_q;
    assign bus.bit_valid      = bit_valid_q;
    assign bus.bit_valid_last = bit_last_q;
    assign bus.busy           = busy_q;
    assign bus.underrun       = underrun_q;

endmodule
